// File: rtl/cdc_fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// cdc_fifo_arb_pkg
// Shared types and constants for the CDC FIFO source-side arbiter.
//   arb_state_e     : arbiter FSM state (IDLE / LOCKED)
//   STAT_CNT_WIDTH  : width of the optional per-requester packet counters
//                     (compiled in with CDC_FIFO_ARB_STATS_EN)
// ---------------------------------------------------------------------------
package cdc_fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned STAT_CNT_WIDTH = 16;

endpackage

// File: rtl/cdc_fifo_src_arbiter_rr_prio_sel.sv
// ---------------------------------------------------------------------------
// rr_prio_sel
// Combinational round-robin priority search: returns the first set bit of
// req_i at or after ptr_i, wrapping modulo NumReq. Works for any NumReq,
// including non-powers of two (the wrap is an explicit compare, not a
// bit-width overflow).
// Ports:
//   req_i    in  NumReq   request vector
//   ptr_i    in  IdWidth  search start index (must be < NumReq)
//   idx_o    out IdWidth  index of the selected request
//   found_o  out 1        at least one request bit set
// ---------------------------------------------------------------------------
module rr_prio_sel #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] ptr_i,
  output logic [IdWidth-1:0] idx_o,
  output logic               found_o
);

  int unsigned        cand;
  logic [IdWidth-1:0] cand_idx;

  always_comb begin
    idx_o    = '0;
    found_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NumReq) begin
        cand = cand - NumReq;
      end
      cand_idx = cand[IdWidth-1:0];
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_src_arbiter.sv
// ---------------------------------------------------------------------------
// cdc_fifo_src_arbiter
// Round-robin, packet-locking arbiter sharing the push port of one CDC FIFO
// between NumReq requesters, entirely in the FIFO source clock domain. Each
// beat is tagged with its requester index so the far side can demultiplex.
// The output stage is a single register; fifo_ready_i only reaches the
// arbitration logic through the slot-free term.
//
// Optional feature: define CDC_FIFO_ARB_STATS_EN to add per-requester 16-bit
// completed-packet counters (stat_pkt_cnt_o) with a synchronous clear
// (stat_clr_i). Without the macro those ports do not exist.
//
// Ports:
//   clk_i           in  1           clock
//   rst_ni          in  1           asynchronous active-low reset
//   req_valid_i     in  NumReq      per-requester beat valid
//   req_ready_o     out NumReq      per-requester beat accepted (one-hot/0)
//   req_data_i      in  NumReq x T  per-requester payload
//   req_last_i      in  NumReq      beat ends the packet
//   fifo_valid_o    out 1           beat valid to FIFO push port
//   fifo_ready_i    in  1           FIFO push ready
//   fifo_data_o     out T           payload
//   fifo_id_o       out IdWidth     requester index of current beat
//   fifo_last_o     out 1           last flag of current beat
//   stat_clr_i      in  1           (stats build) clear all counters
//   stat_pkt_cnt_o  out NumReq x 16 (stats build) packets per requester
//   busy_o          out 1           LOCKED or output beat pending
// ---------------------------------------------------------------------------
module cdc_fifo_src_arbiter
  import cdc_fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq  = 4,
  parameter type         T       = logic,
  localparam int unsigned IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_valid_i,
  output logic [NumReq-1:0]    req_ready_o,
  input  T     [NumReq-1:0]    req_data_i,
  input  logic [NumReq-1:0]    req_last_i,
  output logic                 fifo_valid_o,
  input  logic                 fifo_ready_i,
  output T                     fifo_data_o,
  output logic [IdWidth-1:0]   fifo_id_o,
  output logic                 fifo_last_o,
`ifdef CDC_FIFO_ARB_STATS_EN
  input  logic                 stat_clr_i,
  output logic [NumReq-1:0][STAT_CNT_WIDTH-1:0] stat_pkt_cnt_o,
`endif
  output logic                 busy_o
);

  localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NumReq - 1);

  arb_state_e         state_reg, state_next;
  logic [IdWidth-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IdWidth-1:0] lock_id_reg, lock_id_next;

  logic               fifo_valid_reg;
  T                   fifo_data_reg;
  logic [IdWidth-1:0] fifo_id_reg;
  logic               fifo_last_reg;

  logic               slot_free;
  logic [IdWidth-1:0] rr_idx;
  logic               rr_found;
  logic [IdWidth-1:0] grant_idx;
  logic               grant_en;
  logic               accept;
  logic               acc_last;
  T                   acc_data;
  logic [IdWidth-1:0] grant_inc;

  // The output register can take a new beat when empty or draining this cycle.
  assign slot_free = !fifo_valid_reg || fifo_ready_i;

  rr_prio_sel #(
    .NumReq  (NumReq),
    .IdWidth (IdWidth)
  ) u_rr_prio_sel (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_reg),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  // While locked the owner is granted even when it is not valid, so a
  // stalled owner stalls the whole port rather than letting others interleave.
  always_comb begin
    grant_idx = rr_idx;
    grant_en  = rr_found;
    if (state_reg == LOCKED) begin
      grant_idx = lock_id_reg;
      grant_en  = 1'b1;
    end
  end

  // Readiness is forced low during reset so no requester sees a phantom accept.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
    assign req_ready_o[gi] = rst_ni && grant_en && slot_free
                             && (grant_idx == IdWidth'(gi));
  end

  assign accept    = |(req_valid_i & req_ready_o);
  assign acc_last  = req_last_i[grant_idx];
  assign acc_data  = req_data_i[grant_idx];
  assign grant_inc = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    lock_id_next = lock_id_reg;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (acc_last) begin
            rr_ptr_next = grant_inc;
          end else begin
            state_next   = LOCKED;
            lock_id_next = grant_idx;
          end
        end
        LOCKED: begin
          if (acc_last) begin
            state_next  = IDLE;
            rr_ptr_next = grant_inc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      lock_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      lock_id_reg <= lock_id_next;
    end
  end

  // Output register: load on accept, drop valid when drained without a
  // replacement, otherwise hold (covers the back-pressure case).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_valid_reg <= 1'b0;
      fifo_data_reg  <= '0;
      fifo_id_reg    <= '0;
      fifo_last_reg  <= 1'b0;
    end else if (accept) begin
      fifo_valid_reg <= 1'b1;
      fifo_data_reg  <= acc_data;
      fifo_id_reg    <= grant_idx;
      fifo_last_reg  <= acc_last;
    end else if (fifo_ready_i) begin
      fifo_valid_reg <= 1'b0;
    end
  end

  assign fifo_valid_o = fifo_valid_reg;
  assign fifo_data_o  = fifo_data_reg;
  assign fifo_id_o    = fifo_id_reg;
  assign fifo_last_o  = fifo_last_reg;
  assign busy_o       = (state_reg == LOCKED) || fifo_valid_reg;

`ifdef CDC_FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_stats
    logic [STAT_CNT_WIDTH-1:0] cnt_reg;

    // Clear has priority; the counter wraps naturally at its width.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_reg <= '0;
      end else if (stat_clr_i) begin
        cnt_reg <= '0;
      end else if (req_valid_i[gi] && req_ready_o[gi] && req_last_i[gi]) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign stat_pkt_cnt_o[gi] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdc_fifo_src_arbiter
// Self-checking bench for cdc_fifo_src_arbiter (NumReq=4, 8-bit payload).
// Requesters are modelled as per-requester beat lists; expected output beats
// are queued in the order the arbitration rules dictate and compared as the
// FIFO port consumes them. Stats checks are compiled in only with
// CDC_FIFO_ARB_STATS_EN.
// ---------------------------------------------------------------------------
module tb_cdc_fifo_src_arbiter;

  localparam int NumReq = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NumReq-1:0]      req_valid_i;
  logic [NumReq-1:0]      req_ready_o;
  logic [NumReq-1:0][7:0] req_data_i;
  logic [NumReq-1:0]      req_last_i;
  logic                   fifo_valid_o;
  logic                   fifo_ready_i;
  logic [7:0]             fifo_data_o;
  logic [1:0]             fifo_id_o;
  logic                   fifo_last_o;
  logic                   busy_o;
`ifdef CDC_FIFO_ARB_STATS_EN
  logic                   stat_clr_i;
  logic [NumReq-1:0][15:0] stat_pkt_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  cdc_fifo_src_arbiter #(
    .NumReq (NumReq),
    .T      (logic [7:0])
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_data_i     (req_data_i),
    .req_last_i     (req_last_i),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_ready_i   (fifo_ready_i),
    .fifo_data_o    (fifo_data_o),
    .fifo_id_o      (fifo_id_o),
    .fifo_last_o    (fifo_last_o),
`ifdef CDC_FIFO_ARB_STATS_EN
    .stat_clr_i     (stat_clr_i),
    .stat_pkt_cnt_o (stat_pkt_cnt_o),
`endif
    .busy_o         (busy_o)
  );

  int checks = 0;
  int errors = 0;
  int beats  = 0;

  // Requester beat lists: {last, data}
  logic [8:0] rmem [NumReq][32];
  int         rhead [NumReq];
  int         rtail [NumReq];

  // Scoreboard of expected output beats: {id[1:0], last, data[7:0]}
  logic [10:0] sb [$];

  logic [NumReq-1:0] rdy_s;
  logic              fv_s;
  logic [10:0]       out_s;
  logic              prev_fv;
  logic              prev_frdy;
  logic              prev_hs_any;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s observed=%0h required=%0h", tag, obs, req);
    end
  endtask

  function automatic logic [10:0] mk_beat(input int id, input logic [7:0] d, input logic l);
    return {2'(id), l, d};
  endfunction

  task automatic load(input int g, input logic [7:0] d, input logic l);
    rmem[g][rtail[g]] = {l, d};
    rtail[g]++;
  endtask

  task automatic expect_beat(input int g, input logic [7:0] d, input logic l);
    sb.push_back(mk_beat(g, d, l));
  endtask

  // Present each requester's head beat; valid stays up until it is accepted.
  task automatic drive();
    for (int g = 0; g < NumReq; g++) begin
      if (rhead[g] < rtail[g]) begin
        req_valid_i[g] = 1'b1;
        req_data_i[g]  = rmem[g][rhead[g]][7:0];
        req_last_i[g]  = rmem[g][rhead[g]][8];
      end else begin
        req_valid_i[g] = 1'b0;
        req_data_i[g]  = 8'h00;
        req_last_i[g]  = 1'b0;
      end
    end
  endtask

  // One clock: sample at the falling edge, retire handshakes, re-drive after
  // the rising edge.
  task automatic tick();
    logic [NumReq-1:0] hs;
    logic [10:0]       exp_v;
    @(negedge clk_i);
    rdy_s = req_ready_o;
    fv_s  = fifo_valid_o;
    out_s = {fifo_id_o, fifo_last_o, fifo_data_o};
    chk("rdy_onehot", 32'($onehot0(req_ready_o)), 1);
    if (!prev_fv || prev_frdy) begin
      chk("lat1", 32'(fifo_valid_o), 32'(prev_hs_any));
    end
    if (fifo_valid_o && fifo_ready_i) begin
      beats++;
      $display("beat id=%0d data=%h last=%0d t=%0t", fifo_id_o, fifo_data_o, fifo_last_o, $time);
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        chk("beat", 32'(out_s), 32'(exp_v));
      end
    end
    hs = req_valid_i & req_ready_o;
    for (int g = 0; g < NumReq; g++) begin
      if (hs[g]) rhead[g]++;
    end
    prev_hs_any = |hs;
    prev_fv     = fifo_valid_o;
    prev_frdy   = fifo_ready_i;
    @(posedge clk_i);
    #1;
    drive();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    for (int g = 0; g < NumReq; g++) begin
      rhead[g] = 0;
      rtail[g] = 0;
    end
    prev_fv      = 1'b0;
    prev_frdy    = 1'b1;
    prev_hs_any  = 1'b0;
    rst_ni       = 1'b0;
    fifo_ready_i = 1'b1;
    req_valid_i  = '1;
    req_data_i   = '0;
    req_last_i   = '1;
`ifdef CDC_FIFO_ARB_STATS_EN
    stat_clr_i   = 1'b0;
`endif

    // Reset state, with all requesters valid to show ready is held low.
    #12;
    chk("rst_valid", 32'(fifo_valid_o), 0);
    chk("rst_data",  32'(fifo_data_o), 0);
    chk("rst_id",    32'(fifo_id_o), 0);
    chk("rst_last",  32'(fifo_last_o), 0);
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    req_valid_i = '0;
    req_last_i  = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    drive();

    // 1: single-beat packets from everyone, rotation 0,1,2,3,0, no bubbles.
    for (int g = 0; g < NumReq; g++) load(g, 8'hA0 + 8'(g), 1'b1);
    load(0, 8'hA4, 1'b1);
    for (int g = 0; g < NumReq; g++) expect_beat(g, 8'hA0 + 8'(g), 1'b1);
    expect_beat(0, 8'hA4, 1'b1);
    drive();
    b0 = beats;
    for (int i = 0; i < 6; i++) tick();
    chk("t1_beats", 32'(beats - b0), 5);
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // 2: requester 1 locks for 3 beats while requester 2 waits (ptr is 1).
    load(1, 8'h11, 1'b0);
    load(1, 8'h12, 1'b0);
    load(1, 8'h13, 1'b1);
    load(2, 8'h20, 1'b1);
    expect_beat(1, 8'h11, 1'b0);
    expect_beat(1, 8'h12, 1'b0);
    expect_beat(1, 8'h13, 1'b1);
    expect_beat(2, 8'h20, 1'b1);
    drive();
    tick();
    chk("t2_busy_locked", 32'(busy_o), 1);
    tick();
    chk("t2_r2_blocked_b", 32'(rdy_s[2]), 0);
    tick();
    chk("t2_r2_blocked_c", 32'(rdy_s[2]), 0);
    tick();
    chk("t2_r2_granted", 32'(rdy_s[2]), 1);
    for (int i = 0; i < 2; i++) tick();
    chk("t2_sb_empty", 32'(sb.size()), 0);

    // 3: back-pressure for 5 cycles with a beat pending (ptr is 3).
    fifo_ready_i = 1'b0;
    load(0, 8'h30, 1'b1);
    load(1, 8'h31, 1'b1);
    expect_beat(0, 8'h30, 1'b1);
    expect_beat(1, 8'h31, 1'b1);
    drive();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", 32'(fv_s), 1);
      chk("t3_hold_out", 32'(out_s), 32'(mk_beat(0, 8'h30, 1'b1)));
      chk("t3_hold_ready", 32'(rdy_s), 0);
    end
    fifo_ready_i = 1'b1;
    b0 = beats;
    for (int i = 0; i < 3; i++) tick();
    chk("t3_beats", 32'(beats - b0), 2);
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // 4: lock on requester 3 (ptr is 2), owner idles 4 cycles, requester 0 waits.
    load(3, 8'h40, 1'b0);
    load(0, 8'h50, 1'b1);
    expect_beat(3, 8'h40, 1'b0);
    expect_beat(3, 8'h41, 1'b1);
    expect_beat(0, 8'h50, 1'b1);
    drive();
    tick();
    chk("t4_r0_wait_a", 32'(rdy_s[0]), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_r0_wait", 32'(rdy_s[0]), 0);
      chk("t4_owner_ready", 32'(rdy_s[3]), 1);
      if (i > 0) chk("t4_no_beat", 32'(fv_s), 0);
    end
    load(3, 8'h41, 1'b1);
    drive();
    for (int i = 0; i < 4; i++) tick();
    chk("t4_sb_empty", 32'(sb.size()), 0);

    // 5: asynchronous reset mid-packet with a beat waiting (ptr is 1).
    fifo_ready_i = 1'b0;
    load(2, 8'h60, 1'b0);
    load(2, 8'h61, 1'b0);
    drive();
    tick();
    chk("t5_pre_valid", 32'(fifo_valid_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(fifo_valid_o), 0);
    chk("t5_rst_busy", 32'(busy_o), 0);
    chk("t5_rst_ready", 32'(req_ready_o), 0);
    for (int g = 0; g < NumReq; g++) rhead[g] = rtail[g];
    fifo_ready_i = 1'b1;
    drive();
    prev_fv     = 1'b0;
    prev_frdy   = 1'b1;
    prev_hs_any = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    for (int g = 0; g < NumReq; g++) begin
      load(g, 8'h80 + 8'(g), 1'b1);
      expect_beat(g, 8'h80 + 8'(g), 1'b1);
    end
    drive();
    tick();
    chk("t5_first_grant", 32'(rdy_s), 32'h1);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_sb_empty", 32'(sb.size()), 0);

`ifdef CDC_FIFO_ARB_STATS_EN
    // 6: packet counters with clear priority.
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    chk("t6_cleared", 32'(stat_pkt_cnt_o[2]), 0);
    for (int i = 0; i < 5; i++) begin
      load(2, 8'hB0 + 8'(i), 1'b1);
      expect_beat(2, 8'hB0 + 8'(i), 1'b1);
    end
    drive();
    for (int i = 0; i < 7; i++) tick();
    chk("t6_cnt5", 32'(stat_pkt_cnt_o[2]), 5);
    load(2, 8'hB5, 1'b1);
    expect_beat(2, 8'hB5, 1'b1);
    drive();
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    chk("t6_clr_wins", 32'(stat_pkt_cnt_o[2]), 0);
    for (int i = 0; i < 2; i++) tick();
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    chk("final_sb_empty", 32'(sb.size()), 0);
    chk("final_idle", 32'(busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
